mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one memory read channel and one memory
// write channel among NUM_CONSUMERS load/store units, one transaction at a time.
module mem_arbiter #(
    parameter int NUM_CONSUMERS = 4,
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic [NUM_CONSUMERS-1:0] consumer_read_valid,
    input  logic [ADDR_BITS-1:0]     consumer_read_address [NUM_CONSUMERS],
    output logic [NUM_CONSUMERS-1:0] consumer_read_ready,
    output logic [DATA_BITS-1:0]     consumer_read_data [NUM_CONSUMERS],

    input  logic [NUM_CONSUMERS-1:0] consumer_write_valid,
    input  logic [ADDR_BITS-1:0]     consumer_write_address [NUM_CONSUMERS],
    input  logic [DATA_BITS-1:0]     consumer_write_data [NUM_CONSUMERS],
    output logic [NUM_CONSUMERS-1:0] consumer_write_ready,

    output logic                     mem_read_valid,
    output logic [ADDR_BITS-1:0]     mem_read_address,
    input  logic                     mem_read_ready,
    input  logic [DATA_BITS-1:0]     mem_read_data,

    output logic                     mem_write_valid,
    output logic [ADDR_BITS-1:0]     mem_write_address,
    output logic [DATA_BITS-1:0]     mem_write_data,
    input  logic                     mem_write_ready,

    output logic                     busy
);

    localparam int PTR_BITS = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
    localparam logic [PTR_BITS-1:0] LAST = PTR_BITS'(NUM_CONSUMERS - 1);

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] READ_WAIT  = 2'd1;
    localparam logic [1:0] WRITE_WAIT = 2'd2;
    localparam logic [1:0] RELAY      = 2'd3;

    logic [1:0]          state;
    logic [PTR_BITS-1:0] rr_ptr;
    logic [PTR_BITS-1:0] owner;
    logic                serving_read;

    logic                found;
    logic [PTR_BITS-1:0] winner;
    logic [PTR_BITS-1:0] cand;

    // Scan from rr_ptr upward with wrap; the first consumer asking for anything wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int i = 0; i < NUM_CONSUMERS; i++) begin
            cand = PTR_BITS'((int'(rr_ptr) + i) % NUM_CONSUMERS);
            if (!found && (consumer_read_valid[cand] || consumer_write_valid[cand])) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state                <= IDLE;
            rr_ptr               <= '0;
            owner                <= '0;
            serving_read         <= 1'b0;
            busy                 <= 1'b0;
            mem_read_valid       <= 1'b0;
            mem_read_address     <= '0;
            mem_write_valid      <= 1'b0;
            mem_write_address    <= '0;
            mem_write_data       <= '0;
            consumer_read_ready  <= '0;
            consumer_write_ready <= '0;
            for (int i = 0; i < NUM_CONSUMERS; i++) begin
                consumer_read_data[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        owner <= winner;
                        busy  <= 1'b1;
                        // A winner asking for both gets the read now; its write waits for a later grant.
                        if (consumer_read_valid[winner]) begin
                            serving_read     <= 1'b1;
                            mem_read_valid   <= 1'b1;
                            mem_read_address <= consumer_read_address[winner];
                            state            <= READ_WAIT;
                        end else begin
                            serving_read      <= 1'b0;
                            mem_write_valid   <= 1'b1;
                            mem_write_address <= consumer_write_address[winner];
                            mem_write_data    <= consumer_write_data[winner];
                            state             <= WRITE_WAIT;
                        end
                    end
                end
                READ_WAIT: begin
                    if (mem_read_ready) begin
                        consumer_read_data[owner]  <= mem_read_data;
                        consumer_read_ready[owner] <= 1'b1;
                        mem_read_valid             <= 1'b0;
                        state                      <= RELAY;
                    end
                end
                WRITE_WAIT: begin
                    if (mem_write_ready) begin
                        consumer_write_ready[owner] <= 1'b1;
                        mem_write_valid             <= 1'b0;
                        state                       <= RELAY;
                    end
                end
                RELAY: begin
                    // Hold ready until the owner withdraws the request that was just serviced.
                    if (serving_read ? !consumer_read_valid[owner] : !consumer_write_valid[owner]) begin
                        consumer_read_ready  <= '0;
                        consumer_write_ready <= '0;
                        rr_ptr               <= (owner == LAST) ? '0 : owner + PTR_BITS'(1);
                        busy                 <= 1'b0;
                        state                <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a transaction-level model predicts every output each
// cycle, and directed scenarios pin grant order and data with literal values.
module tb_mem_arbiter;

    localparam int NC = 4;
    localparam int AW = 8;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [NC-1:0] rv, wv, rrdy, wrdy;
    logic [AW-1:0] ra [NC];
    logic [AW-1:0] wa [NC];
    logic [DW-1:0] wd [NC];
    logic [DW-1:0] rdata [NC];
    logic          mrv, mrr, mwv, mwr, busy;
    logic [AW-1:0] mra, mwa;
    logic [DW-1:0] mrd, mwd;

    int checks = 0;
    int failures = 0;
    int memLatency;
    int rdWait, wrWait;
    int wrReadyCycles [NC];
    int grantLog [$];
    logic [DW-1:0] respMem [256];

    logic [DW-1:0] shadowMem [256];
    logic [DW-1:0] expRdata [NC];
    logic          mActive, mRelaying, mIsRead;
    int            mOwner, mPtr, cand;
    logic [AW-1:0] mAddr;
    logic [DW-1:0] mData, mExpData;
    logic [NC-1:0] expRrdy, expWrdy;
    logic          prevReset, prevMrr, prevMwr, stillValid;
    logic [NC-1:0] prevRv, prevWv;
    logic [AW-1:0] prevRa [NC];
    logic [AW-1:0] prevWa [NC];
    logic [DW-1:0] prevWd [NC];

    mem_arbiter #(.NUM_CONSUMERS(NC), .ADDR_BITS(AW), .DATA_BITS(DW)) dut (
        .clk(clk),
        .reset(reset),
        .consumer_read_valid(rv),
        .consumer_read_address(ra),
        .consumer_read_ready(rrdy),
        .consumer_read_data(rdata),
        .consumer_write_valid(wv),
        .consumer_write_address(wa),
        .consumer_write_data(wd),
        .consumer_write_ready(wrdy),
        .mem_read_valid(mrv),
        .mem_read_address(mra),
        .mem_read_ready(mrr),
        .mem_read_data(mrd),
        .mem_write_valid(mwv),
        .mem_write_address(mwa),
        .mem_write_data(mwd),
        .mem_write_ready(mwr),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s at %0t: actual=0x%0h expected=0x%0h", name, $time, actual, expected);
        end
    endtask

    // One clock of stimulus; consumers withdraw a request as soon as they see its ready.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        for (int i = 0; i < NC; i++) begin
            if (rrdy[i]) rv[i] = 1'b0;
            if (wrdy[i]) wv[i] = 1'b0;
        end
    endtask

    task automatic waitQuiet(input string name, input int budget);
        int n = 0;
        while ((rv != '0 || wv != '0 || busy) && n < budget) begin
            applyStimulus();
            n++;
        end
        checkOutput(name, 32'(n < budget), 32'd1);
    endtask

    function automatic logic [31:0] logSig();
        logic [31:0] s = '0;
        foreach (grantLog[i]) s = (s << 8) | 32'(grantLog[i]);
        return s;
    endfunction

    // Memory responder: raises ready memLatency cycles after it first sees valid.
    initial begin
        for (int a = 0; a < 256; a++) respMem[a] = DW'(a) ^ 8'hB9;
        mrr = 1'b0; mwr = 1'b0; mrd = '0;
        rdWait = 0; wrWait = 0;
        forever begin
            @(posedge clk);
            #2;
            mrr = 1'b0;
            mwr = 1'b0;
            if (mrv === 1'b1) begin
                if (rdWait >= memLatency) begin
                    mrr = 1'b1; mrd = respMem[mra]; rdWait = 0;
                end else rdWait++;
            end else rdWait = 0;
            if (mwv === 1'b1) begin
                if (wrWait >= memLatency) begin
                    mwr = 1'b1; respMem[mwa] = mwd; wrWait = 0;
                end else wrWait++;
            end else wrWait = 0;
        end
    end

    // Reference model: one transaction at a time, granted round-robin from mPtr,
    // completed by the memory handshake, released when the owner drops its request.
    initial begin
        for (int a = 0; a < 256; a++) shadowMem[a] = DW'(a) ^ 8'hB9;
        for (int i = 0; i < NC; i++) begin
            expRdata[i] = '0; wrReadyCycles[i] = 0;
            prevRa[i] = '0; prevWa[i] = '0; prevWd[i] = '0;
        end
        mActive = 1'b0; mRelaying = 1'b0; mIsRead = 1'b0; mOwner = 0; mPtr = 0;
        mAddr = '0; mData = '0; mExpData = '0;
        prevReset = 1'b1; prevMrr = 1'b0; prevMwr = 1'b0; prevRv = '0; prevWv = '0;
        forever begin
            @(negedge clk);
            if (prevReset) begin
                mActive = 1'b0; mRelaying = 1'b0; mPtr = 0;
                for (int i = 0; i < NC; i++) expRdata[i] = '0;
                checkOutput("reset_mem_read_address", 32'(mra), 32'd0);
                checkOutput("reset_mem_write_address", 32'(mwa), 32'd0);
                checkOutput("reset_mem_write_data", 32'(mwd), 32'd0);
            end else if (mActive && mRelaying) begin
                stillValid = mIsRead ? prevRv[mOwner] : prevWv[mOwner];
                if (!stillValid) begin
                    mActive = 1'b0; mRelaying = 1'b0; mPtr = (mOwner + 1) % NC;
                end
            end else if (mActive) begin
                if (mIsRead ? prevMrr : prevMwr) begin
                    mRelaying = 1'b1;
                    if (mIsRead) expRdata[mOwner] = mExpData;
                end
            end else begin
                for (int k = 0; k < NC; k++) begin
                    cand = (mPtr + k) % NC;
                    if (!mActive && (prevRv[cand] || prevWv[cand])) begin
                        mActive = 1'b1; mRelaying = 1'b0; mOwner = cand; mIsRead = prevRv[cand];
                        if (mIsRead) begin
                            mAddr = prevRa[cand]; mExpData = shadowMem[mAddr];
                        end else begin
                            mAddr = prevWa[cand]; mData = prevWd[cand]; shadowMem[mAddr] = mData;
                        end
                        grantLog.push_back(mIsRead ? cand : 16 + cand);
                    end
                end
            end

            expRrdy = (mActive && mRelaying && mIsRead)  ? (NC'(1) << mOwner) : '0;
            expWrdy = (mActive && mRelaying && !mIsRead) ? (NC'(1) << mOwner) : '0;
            checkOutput("busy", 32'(busy), 32'(mActive));
            checkOutput("mem_read_valid", 32'(mrv), 32'(mActive && !mRelaying && mIsRead));
            checkOutput("mem_write_valid", 32'(mwv), 32'(mActive && !mRelaying && !mIsRead));
            if (mActive && !mRelaying && mIsRead) checkOutput("mem_read_address", 32'(mra), 32'(mAddr));
            if (mActive && !mRelaying && !mIsRead) begin
                checkOutput("mem_write_address", 32'(mwa), 32'(mAddr));
                checkOutput("mem_write_data", 32'(mwd), 32'(mData));
            end
            checkOutput("consumer_read_ready", 32'(rrdy), 32'(expRrdy));
            checkOutput("consumer_write_ready", 32'(wrdy), 32'(expWrdy));
            for (int i = 0; i < NC; i++) begin
                checkOutput($sformatf("consumer_read_data[%0d]", i), 32'(rdata[i]), 32'(expRdata[i]));
                if (wrdy[i] === 1'b1) wrReadyCycles[i]++;
            end

            prevReset = reset; prevRv = rv; prevWv = wv;
            prevRa = ra; prevWa = wa; prevWd = wd;
            prevMrr = mrr; prevMwr = mwr;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        reset = 1'b1; rv = '0; wv = '0; memLatency = 0;
        for (int i = 0; i < NC; i++) begin
            ra[i] = '0; wa[i] = '0; wd[i] = '0;
        end
        repeat (3) applyStimulus();
        reset = 1'b0;
        applyStimulus();
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_mem_read_valid", 32'(mrv), 32'd0);
        checkOutput("reset_read_data0", 32'(rdata[0]), 32'd0);

        $display("[TB] single read");
        grantLog.delete();
        memLatency = 2; ra[0] = 8'h12; rv[0] = 1'b1;
        applyStimulus();
        checkOutput("single_mem_read_address", 32'(mra), 32'h12);
        ra[0] = 8'h99;
        waitQuiet("single_quiet", 20);
        checkOutput("single_read_data", 32'(rdata[0]), 32'hAB);
        checkOutput("single_order", logSig(), 32'h00);
        checkOutput("single_count", 32'(grantLog.size()), 32'd1);

        $display("[TB] reset during read wait");
        grantLog.delete();
        memLatency = 5; ra[1] = 8'h21; rv[1] = 1'b1;
        applyStimulus();
        checkOutput("rst_pre_read_valid", 32'(mrv), 32'd1);
        applyStimulus();
        reset = 1'b1; rv[1] = 1'b0;
        applyStimulus();
        reset = 1'b0;
        checkOutput("rst_mid_read_valid", 32'(mrv), 32'd0);
        checkOutput("rst_mid_busy", 32'(busy), 32'd0);
        repeat (3) begin
            applyStimulus();
            checkOutput("rst_mid_no_ready", 32'(rrdy), 32'd0);
        end
        grantLog.delete();
        memLatency = 1; ra[0] = 8'h05; ra[3] = 8'h06; rv[0] = 1'b1; rv[3] = 1'b1;
        waitQuiet("rst_fresh_quiet", 30);
        checkOutput("rst_fresh_order", logSig(), 32'h0003);
        checkOutput("rst_fresh_data0", 32'(rdata[0]), 32'hBC);
        checkOutput("rst_fresh_data3", 32'(rdata[3]), 32'hBF);

        $display("[TB] contention");
        grantLog.delete();
        memLatency = 0;
        for (int i = 0; i < NC; i++) ra[i] = 8'h80 + 8'(i);
        rv = '1;
        waitQuiet("contention_quiet", 40);
        checkOutput("contention_order", logSig(), 32'h00010203);
        checkOutput("contention_data2", 32'(rdata[2]), 32'h3B);

        $display("[TB] fairness and wrap");
        grantLog.delete();
        rv[1] = 1'b1; rv[3] = 1'b1;
        n = 0;
        while (!rrdy[1] && n < 20) begin
            applyStimulus();
            n++;
        end
        checkOutput("fair_first_seen", 32'(n < 20), 32'd1);
        applyStimulus();
        rv[1] = 1'b1;
        waitQuiet("fair_quiet", 40);
        checkOutput("fair_order", logSig(), 32'h010301);

        $display("[TB] read and write from one consumer");
        grantLog.delete();
        memLatency = 1;
        ra[2] = 8'h33; wa[2] = 8'h40; wd[2] = 8'h55; rv[2] = 1'b1; wv[2] = 1'b1;
        n = 0;
        while (!mwv && n < 30) begin
            applyStimulus();
            n++;
        end
        checkOutput("rw_write_seen", 32'(n < 30), 32'd1);
        checkOutput("rw_write_address", 32'(mwa), 32'h40);
        checkOutput("rw_write_data", 32'(mwd), 32'h55);
        waitQuiet("rw_quiet", 30);
        checkOutput("rw_order", logSig(), 32'h0212);
        checkOutput("rw_read_data", 32'(rdata[2]), 32'h8A);
        ra[0] = 8'h40; rv[0] = 1'b1;
        waitQuiet("rw_readback_quiet", 30);
        checkOutput("rw_readback", 32'(rdata[0]), 32'h55);

        $display("[TB] early drop of write request");
        grantLog.delete();
        wrReadyCycles[1] = 0;
        memLatency = 4; wa[1] = 8'h10; wd[1] = 8'h77; wv[1] = 1'b1;
        applyStimulus();
        checkOutput("drop_write_valid", 32'(mwv), 32'd1);
        wv[1] = 1'b0;
        applyStimulus();
        applyStimulus();
        checkOutput("drop_no_abort", 32'(mwv), 32'd1);
        checkOutput("drop_write_address", 32'(mwa), 32'h10);
        waitQuiet("drop_quiet", 20);
        checkOutput("drop_ready_cycles", 32'(wrReadyCycles[1]), 32'd1);
        checkOutput("drop_order", logSig(), 32'h11);
        applyStimulus();
        checkOutput("drop_idle", 32'(busy), 32'd0);
        memLatency = 0; ra[2] = 8'h10; rv[2] = 1'b1;
        waitQuiet("drop_readback_quiet", 20);
        checkOutput("drop_readback", 32'(rdata[2]), 32'h77);

        repeat (2) applyStimulus();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
